// File: rtl/sb_arb_pkg.sv
// rtl/sb_arb_pkg.sv - shared widths, constants and enums for the dmem arbiter
package sb_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WE_W   = 4;

    localparam logic [DATA_W-1:0] ZERO32 = 32'h0000_0000;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

endpackage

// File: rtl/sb_arb_if.sv
// rtl/sb_arb_if.sv - two-master request bus plus dmem port seen by the arbiter
interface sb_arb_if;
    import sb_arb_pkg::*;

    logic              m0_req;
    logic [WE_W-1:0]   m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;

    logic              m1_req;
    logic [WE_W-1:0]   m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;

    logic [DATA_W-1:0] rdata;
    logic [WE_W-1:0]   s_rw;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  s_rdata,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        output rdata, s_rw, s_addr, s_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output s_rdata,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        input  rdata, s_rw, s_addr, s_wdata
    );

endinterface

// File: rtl/sb_arb_rr.sv
// rtl/sb_arb_rr.sv - winner pick and streak tracking for the two-master arbiter
module sb_arb_rr
    import sb_arb_pkg::*;
#(
    parameter int QUANTUM = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    en_i,
    input  logic    req0_i,
    input  logic    req1_i,
    output logic    gnt_valid_o,
    output master_e pick_o
);

    localparam logic [3:0] QMAX = 4'(QUANTUM);

    master_e    last_q, last_d;
    logic [3:0] streak_q, streak_d;
    logic       keep_last;
    master_e    other;

    // A zero streak means nobody holds the bus yet, so the non-last master wins the tie.
    assign keep_last = (streak_q != 4'd0) && (streak_q < QMAX);
    assign other     = (last_q == M0) ? M1 : M0;

    always_comb begin
        gnt_valid_o = en_i && (req0_i || req1_i);
        pick_o      = M0;
        if (req0_i && req1_i) begin
            pick_o = keep_last ? last_q : other;
        end else if (req1_i) begin
            pick_o = M1;
        end
    end

    always_comb begin
        last_d   = last_q;
        streak_d = streak_q;
        if (gnt_valid_o) begin
            last_d = pick_o;
            if (pick_o != last_q) begin
                streak_d = 4'd1;
            end else if (streak_q < QMAX) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= M1;
            streak_q <= 4'd0;
        end else begin
            last_q   <= last_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/sb_arb.sv
// rtl/sb_arb.sv - two-master dmem arbiter: single-cycle writes, one-wait-state reads
module sb_arb
    import sb_arb_pkg::*;
#(
    parameter int QUANTUM = 4
) (
    input  logic     clk,
    input  logic     rst,
    sb_arb_if.slave  bus
);

    state_e  state_q, state_d;
    master_e owner_q, owner_d;
    logic    gnt_valid;
    master_e pick;

    sb_arb_rr #(.QUANTUM(QUANTUM)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .en_i        ((state_q == IDLE) && !rst),
        .req0_i      (bus.m0_req),
        .req1_i      (bus.m1_req),
        .gnt_valid_o (gnt_valid),
        .pick_o      (pick)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        bus.m0_gnt    = 1'b0;
        bus.m1_gnt    = 1'b0;
        bus.m0_rvalid = 1'b0;
        bus.m1_rvalid = 1'b0;
        bus.rdata     = ZERO32;
        bus.s_rw      = '0;
        bus.s_addr    = ZERO32;
        bus.s_wdata   = ZERO32;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    if (pick == M0) begin
                        bus.m0_gnt  = 1'b1;
                        bus.s_rw    = bus.m0_we;
                        bus.s_addr  = bus.m0_addr;
                        bus.s_wdata = bus.m0_wdata;
                    end else begin
                        bus.m1_gnt  = 1'b1;
                        bus.s_rw    = bus.m1_we;
                        bus.s_addr  = bus.m1_addr;
                        bus.s_wdata = bus.m1_wdata;
                    end
                    // Writes retire in the grant cycle; only reads need the wait state.
                    if (bus.s_rw == '0) begin
                        state_d = RD_WAIT;
                        owner_d = pick;
                    end
                end
            end
            RD_WAIT: begin
                state_d = IDLE;
                if (!rst) begin
                    bus.rdata = bus.s_rdata;
                    if (owner_q == M0) begin
                        bus.m0_rvalid = 1'b1;
                    end else begin
                        bus.m1_rvalid = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= M0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_sb_arb.sv
// tb/tb_sb_arb.sv - directed self-checking bench for sb_arb
module tb_sb_arb;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sb_arb_if bus ();

    sb_arb #(.QUANTUM(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // dmem stand-in: word 0x10 holds DEADBEEF, every other address reads back as ~addr
    always @(posedge clk) begin
        bus.s_rdata <= (bus.s_addr == 32'h10) ? 32'hDEADBEEF : ~bus.s_addr;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.m0_req = 1'b0; bus.m0_we = 4'h0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
        bus.m1_req = 1'b0; bus.m1_we = 4'h0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;
    endtask

    task automatic set_writes(input logic r0, input logic r1);
        bus.m0_req = r0; bus.m0_we = 4'hF; bus.m0_addr = 32'h100; bus.m0_wdata = 32'hAAAA_0000;
        bus.m1_req = r1; bus.m1_we = 4'h3; bus.m1_addr = 32'h200; bus.m1_wdata = 32'h0000_5555;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_writes(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid} !== 4'b0000) begin
                errors++; $display("FAIL reset_handshake: got %b want 0000", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid});
            end
            checks++;
            if ({bus.s_rw, bus.s_addr, bus.s_wdata, bus.rdata} !== '0) begin
                errors++; $display("FAIL reset_bus: s_rw=%h s_addr=%h s_wdata=%h rdata=%h want all 0", bus.s_rw, bus.s_addr, bus.s_wdata, bus.rdata);
            end
            next_cycle();
        end
        clear_reqs();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            #4;
            checks++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.s_rw, bus.s_addr, bus.s_wdata, bus.rdata} !== '0) begin
                errors++; $display("FAIL idle_zero[%0d]: gnt=%b%b s_rw=%h s_addr=%h s_wdata=%h rdata=%h want all 0",
                                   i, bus.m0_gnt, bus.m1_gnt, bus.s_rw, bus.s_addr, bus.s_wdata, bus.rdata);
            end
            next_cycle();
        end
    endtask

    task automatic test_quantum();
        logic exp_m0 [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        set_writes(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            #4;
            checks++;
            if ({bus.m0_gnt, bus.m1_gnt} !== {exp_m0[i], !exp_m0[i]}) begin
                errors++; $display("FAIL quantum_gnt[%0d]: got %b%b want %b%b", i, bus.m0_gnt, bus.m1_gnt, exp_m0[i], !exp_m0[i]);
            end
            checks++;
            if (bus.s_rw !== (exp_m0[i] ? 4'hF : 4'h3)) begin
                errors++; $display("FAIL quantum_s_rw[%0d]: got %h want %h", i, bus.s_rw, exp_m0[i] ? 4'hF : 4'h3);
            end
            checks++;
            if (bus.s_wdata !== (exp_m0[i] ? 32'hAAAA_0000 : 32'h0000_5555)) begin
                errors++; $display("FAIL quantum_s_wdata[%0d]: got %h want %h", i, bus.s_wdata, exp_m0[i] ? 32'hAAAA_0000 : 32'h0000_5555);
            end
            next_cycle();
        end
        clear_reqs();
        next_cycle();
    endtask

    task automatic test_saturate();
        set_writes(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #4;
            checks++;
            if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin
                errors++; $display("FAIL sole_m0[%0d]: got %b%b want 10", i, bus.m0_gnt, bus.m1_gnt);
            end
            next_cycle();
        end
        set_writes(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++;
            if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin
                errors++; $display("FAIL saturated_tie[%0d]: got %b%b want 01", i, bus.m0_gnt, bus.m1_gnt);
            end
            next_cycle();
        end
        clear_reqs();
        next_cycle();
    endtask

    task automatic test_read();
        bus.m0_req = 1'b1; bus.m0_we = 4'h0; bus.m0_addr = 32'h10;
        #4;
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.s_rw, bus.s_addr} !== {2'b10, 4'h0, 32'h10}) begin
            errors++; $display("FAIL read_grant: gnt=%b%b s_rw=%h s_addr=%h want gnt=10 s_rw=0 s_addr=10",
                               bus.m0_gnt, bus.m1_gnt, bus.s_rw, bus.s_addr);
        end
        next_cycle();
        clear_reqs();
        #4;
        checks++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_gnt, bus.m1_gnt} !== 4'b1000) begin
            errors++; $display("FAIL read_rvalid: rvalid=%b%b gnt=%b%b want rvalid=10 gnt=00",
                               bus.m0_rvalid, bus.m1_rvalid, bus.m0_gnt, bus.m1_gnt);
        end
        checks++;
        if (bus.rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_rdata: got %h want deadbeef", bus.rdata);
        end
        next_cycle();
        #4;
        checks++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.rdata} !== '0) begin
            errors++; $display("FAIL read_after: rvalid=%b%b rdata=%h want 00 and 0", bus.m0_rvalid, bus.m1_rvalid, bus.rdata);
        end
        next_cycle();
    endtask

    task automatic test_read_collision();
        bus.m0_req = 1'b1; bus.m0_we = 4'h0; bus.m0_addr = 32'h10;
        #4;
        checks++;
        if (bus.m0_gnt !== 1'b1) begin
            errors++; $display("FAIL coll_m0_gnt: got %b want 1", bus.m0_gnt);
        end
        next_cycle();
        clear_reqs();
        bus.m1_req = 1'b1; bus.m1_we = 4'h0; bus.m1_addr = 32'h20;
        #4;
        checks++;
        if ({bus.m1_gnt, bus.m0_rvalid} !== 2'b01) begin
            errors++; $display("FAIL coll_holdoff: m1_gnt=%b m0_rvalid=%b want 0 and 1", bus.m1_gnt, bus.m0_rvalid);
        end
        next_cycle();
        #4;
        checks++;
        if ({bus.m1_gnt, bus.s_addr} !== {1'b1, 32'h20}) begin
            errors++; $display("FAIL coll_m1_gnt: m1_gnt=%b s_addr=%h want 1 and 20", bus.m1_gnt, bus.s_addr);
        end
        next_cycle();
        clear_reqs();
        #4;
        checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid, bus.rdata} !== {2'b10, 32'hFFFF_FFDF}) begin
            errors++; $display("FAIL coll_m1_rvalid: rvalid m1=%b m0=%b rdata=%h want 1 0 ffffffdf",
                               bus.m1_rvalid, bus.m0_rvalid, bus.rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_rd_wait();
        bus.m1_req = 1'b1; bus.m1_we = 4'h0; bus.m1_addr = 32'h30;
        #4;
        checks++;
        if (bus.m1_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_rd_m1_gnt: got %b want 1", bus.m1_gnt);
        end
        next_cycle();
        clear_reqs();
        rst = 1'b1;
        #4;
        checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid, bus.rdata, bus.s_rw, bus.s_addr} !== '0) begin
            errors++; $display("FAIL rst_rd_suppress: rvalid m1=%b m0=%b rdata=%h s_rw=%h s_addr=%h want all 0",
                               bus.m1_rvalid, bus.m0_rvalid, bus.rdata, bus.s_rw, bus.s_addr);
        end
        next_cycle();
        rst = 1'b0;
        #4;
        checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid, bus.m0_gnt, bus.m1_gnt, bus.rdata, bus.s_addr} !== '0) begin
            errors++; $display("FAIL rst_rd_after: rvalid=%b%b gnt=%b%b rdata=%h s_addr=%h want all 0",
                               bus.m0_rvalid, bus.m1_rvalid, bus.m0_gnt, bus.m1_gnt, bus.rdata, bus.s_addr);
        end
        next_cycle();
        set_writes(1'b1, 1'b1);
        #4;
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin
            errors++; $display("FAIL rst_rd_tie: got %b%b want 10", bus.m0_gnt, bus.m1_gnt);
        end
        next_cycle();
        clear_reqs();
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_reqs();
        next_cycle();
        test_reset();
        test_idle();
        test_quantum();
        test_saturate();
        test_read();
        test_read_collision();
        test_reset_rd_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
